lsu_unaligned: RTL and testbench
================================

# lsu_unaligned

Parametrised load/store unit between the core datapath and the data-memory bus port (`data_req`/`data_gnt`/`data_r_valid`). It accepts byte, half, word and (for 64-bit buses) double accesses at any address. It generates aligned bus addresses and byte enables, and splits an access that crosses a bus-word boundary into two back-to-back bus transactions. Load data is reassembled and sign/zero-extended before return, so the core's `MemtoReg` path sees a finished result.

## Interface
Parameters:
- `DATA_W`, 32: bus and register data width; legal values 32 or 64.
- `ADDR_W`, 32: byte address width.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `res` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core access request.
- `req_ready` out 1: high only in IDLE; the access is accepted on `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 byte, 1 half, 2 word, 3 double.
- `req_signed` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_adr` in ADDR_W: byte address, any alignment.
- `req_wdata` in DATA_W: store data, right-aligned.
- `resp_valid` out 1: one-cycle pulse on completion of a load or store.
- `resp_rdata` out DATA_W: extended load data; 0 for stores and errors.
- `resp_err` out 1: qualified by `resp_valid`; illegal size or trapped misalignment.
- `data_req` out 1: bus request.
- `data_gnt` in 1: bus grant.
- `data_adr` out ADDR_W: bus address, aligned to DATA_W/8.
- `data_we` out 1: bus write enable.
- `data_be` out DATA_W/8: byte enables.
- `data_wdata` out DATA_W: lane-shifted store data.
- `data_rdata` in DATA_W: bus read data.
- `data_r_valid` in 1: bus response; asserted for both reads and writes.

## Operation
Derived values:
- NB = DATA_W/8.
- off = `req_adr[log2(NB)-1:0]`.
- n = 1<<`req_size`.
- base = `req_adr` with the low log2(NB) bits cleared.
- split = (off + n > NB).

Error checks:
- `req_size`=3 with DATA_W=32 is illegal: no bus access, `resp_err`=1.

States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: on accept, register all request fields, then go to REQ0, or to RESP if the request is an error.
- REQ0: `data_req`=1, `data_adr`=base, `data_be`=((1<<n)-1)<<off truncated to NB bits, `data_wdata`=wdata<<8·off. On `data_gnt` go to WAIT0.
- WAIT0: on `data_r_valid`, capture `data_rdata` into beat0; go to REQ1 if split, else RESP.
- REQ1: `data_adr`=base+NB (modulo 2^ADDR_W, wraps), `data_be`=((1<<n)-1)>>(NB−off), `data_wdata`=wdata>>8·(NB−off). On `data_gnt` go to WAIT1.
- WAIT1: on `data_r_valid`, capture beat1, then go to RESP.
- RESP: `resp_valid`=1 for one cycle. For a load, `resp_rdata` = low n bytes of ({beat1,beat0}>>8·off), extended per `req_signed`; `req_size`=3 or n=NB returns unextended. Then go to IDLE.

Bus rules:
- Address, be, we and wdata are held stable while `data_req`=1 and until `data_gnt`.
- `data_r_valid` outside WAIT0/WAIT1 is ignored.
- `data_gnt` outside REQ0/REQ1 is ignored.

## Timing
- Reset values: `req_ready`=0 while `res`=0, `data_req`=0, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `data_we`=0, `data_be`=0, `data_adr`=0, `data_wdata`=0; FSM state is IDLE. After release, `req_ready`=1.
- `res` asserted mid-access forces `data_req` low immediately (asynchronous). The in-flight access is dropped with no `resp_valid`.
- Unsplit access, zero-wait bus: accept at T, `data_req`/`data_gnt` at T+1, `data_r_valid` at T+2, `resp_valid` at T+3. A split access adds 2 cycles.
- An error access gives `resp_valid` at T+1 and no bus activity.
- Bus wait states extend REQx/WAITx 1:1. The `data_r_valid` for a beat may not coincide with its `data_gnt` (the bus guarantees this).

## Configuration
- `LSU_SPLIT_ACCESS_EN` defined: boundary-crossing accesses are split as above.
- `LSU_SPLIT_ACCESS_EN` undefined: any access with off mod n ≠ 0 is a misalignment error. It goes IDLE→RESP with `resp_err`=1 and no bus request. REQ1/WAIT1 are not built.

## Test plan
DATA_W=32, zero-wait bus unless stated.
- Load word at 0x100, `data_rdata`=0xDEADBEEF: expect one transaction, `data_be`=1111, `resp_rdata`=0xDEADBEEF at T+3.
- Load half signed at 0x103, beat0 rdata 0xF0000000, beat1 rdata 0x00000081: expect `data_adr` 0x100 be 1000, then 0x104 be 0001, `resp_rdata`=0xFFFF81F0 at T+5.
- Store word 0x11223344 at 0x006: expect beat0 adr 0x004 be 1100 wdata 0x33440000, beat1 adr 0x008 be 0011 wdata 0x00001122, `resp_valid` after the second `data_r_valid`.
- Load byte unsigned at 0x201 with rdata 0x0000AB00, `data_gnt` delayed 3 cycles: expect `data_req` and `data_adr` held for 3 cycles, `resp_rdata`=0x000000AB.
- Load word at 0xFFFFFFFE: expect beat1 `data_adr`=0x00000000. Repeat with `res` pulled low during WAIT0: expect `data_req`=0 immediately, no `resp_valid`, and `req_ready`=1 after release.
- Without `LSU_SPLIT_ACCESS_EN`, load word at 0x102: expect `resp_valid`=1 and `resp_err`=1 at T+1, with `data_req` never asserted. With `req_size`=3 in either build: same error response.

Source files
------------

// File: rtl/lsu_unaligned.sv
// -----------------------------------------------------------------------------
// lsu_unaligned
//
// Load/store unit between the core datapath and the data-memory bus port.
// Accepts byte/half/word (and double on 64-bit buses) accesses at any byte
// address. It produces aligned bus addresses, byte enables and lane-shifted
// store data. Load data is reassembled and sign/zero-extended before it is
// returned, so the core's MemtoReg path gets a finished value.
//
// Build option:
//   LSU_SPLIT_ACCESS_EN  defined   : an access that crosses a bus-word boundary
//                                    becomes two back-to-back bus transactions.
//                        undefined : any access whose offset is not a multiple
//                                    of its size completes with resp_err and
//                                    makes no bus request.
//
// Parameters:
//   DATA_W  bus/register width, 32 or 64
//   ADDR_W  byte address width
//
// Ports:
//   clk, res (async, active-low)
//   req_valid/req_ready/req_we/req_size/req_signed/req_adr/req_wdata : core request
//   resp_valid/resp_rdata/resp_err                                    : core response
//   data_req/data_gnt/data_adr/data_we/data_be/data_wdata             : bus request
//   data_rdata/data_r_valid                                           : bus response
// -----------------------------------------------------------------------------
module lsu_unaligned #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_adr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  data_req,
    input  logic                  data_gnt,
    output logic [ADDR_W-1:0]     data_adr,
    output logic                  data_we,
    output logic [DATA_W/8-1:0]   data_be,
    output logic [DATA_W-1:0]     data_wdata,
    input  logic [DATA_W-1:0]     data_rdata,
    input  logic                  data_r_valid
);

    localparam int NB     = DATA_W / 8;
    localparam int LOG_NB = $clog2(NB);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t state, state_nxt;

    // Sign/zero extension of the low (1<<size) bytes. A full-width access
    // keeps every byte, so it comes back unextended.
    function automatic logic [DATA_W-1:0] extend_load(
        input logic [DATA_W-1:0] raw,
        input logic [1:0]        size,
        input logic              sgn
    );
        logic [DATA_W-1:0] r;
        logic              s;
        int                nbytes;
        nbytes = 1 << size;
        case (size)
            2'd0:    s = raw[7];
            2'd1:    s = raw[15];
            2'd2:    s = raw[31];
            default: s = raw[DATA_W-1];
        endcase
        for (int i = 0; i < NB; i++) begin
            r[8*i +: 8] = (i < nbytes) ? raw[8*i +: 8] : {8{s & sgn}};
        end
        return r;
    endfunction

    // ---------------- request decode (IDLE) ----------------
    logic              ready_q;
    logic              accept;
    logic [LOG_NB-1:0] req_off;
    logic [3:0]        req_n;
    logic              size_bad;
    logic              req_err;

    assign req_ready = ready_q && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_off   = req_adr[LOG_NB-1:0];
    assign req_n     = 4'(1) << req_size;
    assign size_bad  = (req_size == 2'd3) && (DATA_W == 32);

`ifdef LSU_SPLIT_ACCESS_EN
    logic [4:0] off_plus_n;
    logic       req_split;
    assign off_plus_n = 5'(req_off) + 5'(req_n);
    assign req_split  = off_plus_n > 5'(NB);
    assign req_err    = size_bad;
`else
    logic misaligned;
    assign misaligned = (4'(req_off) & (req_n - 4'd1)) != 4'd0;
    assign req_err    = size_bad || misaligned;
`endif

    // ---------------- captured request / beats ----------------
    logic                we_q;
    logic [1:0]          size_q;
    logic                sgn_q;
    logic                err_q;
    logic [LOG_NB-1:0]   off_q;
    logic [ADDR_W-1:0]   base_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   beat0_q;
`ifdef LSU_SPLIT_ACCESS_EN
    logic                split_q;
    logic [DATA_W-1:0]   beat1_q;
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef LSU_SPLIT_ACCESS_EN
            split_q <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            ready_q <= 1'b1;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                sgn_q   <= req_signed;
                err_q   <= req_err;
`ifdef LSU_SPLIT_ACCESS_EN
                split_q <= req_split;
`endif
            end
        end
    end

    // Datapath registers carry no reset: every use is qualified by FSM state.
    always_ff @(posedge clk) begin
        if (accept) begin
            off_q   <= req_off;
            base_q  <= req_adr & ~ADDR_W'(NB - 1);
            wdata_q <= req_wdata;
        end
        if (state == WAIT0 && data_r_valid) beat0_q <= data_rdata;
`ifdef LSU_SPLIT_ACCESS_EN
        if (state == WAIT1 && data_r_valid) beat1_q <= data_rdata;
`endif
    end

    // ---------------- lane steering ----------------
    logic [3:0]        n_q;
    logic [2*NB-1:0]   mask_wide;
    logic [DATA_W-1:0] rd_raw;

    assign n_q       = 4'(1) << size_q;
    assign mask_wide = ((2*NB)'(1) << n_q) - (2*NB)'(1);

`ifdef LSU_SPLIT_ACCESS_EN
    logic [LOG_NB:0]   be_sh1;
    logic [LOG_NB+3:0] wd_sh1;
    assign be_sh1 = (LOG_NB+1)'(NB) - {1'b0, off_q};
    assign wd_sh1 = (LOG_NB+4)'(DATA_W) - {1'b0, off_q, 3'b000};
    // Bytes past the first beat come from the low lanes of beat1.
    assign rd_raw = DATA_W'({beat1_q, beat0_q} >> {off_q, 3'b000});
`else
    assign rd_raw = beat0_q >> {off_q, 3'b000};
`endif

    // ---------------- next state / outputs ----------------
    always_comb begin
        state_nxt  = state;
        data_req   = 1'b0;
        data_adr   = '0;
        data_we    = 1'b0;
        data_be    = '0;
        data_wdata = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = req_err ? RESP : REQ0;
            end
            REQ0: begin
                data_req   = 1'b1;
                data_adr   = base_q;
                data_we    = we_q;
                data_be    = NB'(mask_wide << off_q);
                data_wdata = wdata_q << {off_q, 3'b000};
                if (data_gnt) state_nxt = WAIT0;
            end
            WAIT0: begin
`ifdef LSU_SPLIT_ACCESS_EN
                if (data_r_valid) state_nxt = split_q ? REQ1 : RESP;
`else
                if (data_r_valid) state_nxt = RESP;
`endif
            end
`ifdef LSU_SPLIT_ACCESS_EN
            REQ1: begin
                data_req   = 1'b1;
                data_adr   = base_q + ADDR_W'(NB);
                data_we    = we_q;
                data_be    = NB'(mask_wide >> be_sh1);
                data_wdata = wdata_q >> wd_sh1;
                if (data_gnt) state_nxt = WAIT1;
            end
            WAIT1: begin
                if (data_r_valid) state_nxt = RESP;
            end
`endif
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !we_q) resp_rdata = extend_load(rd_raw, size_q, sgn_q);
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_unaligned.sv
// -----------------------------------------------------------------------------
// tb_lsu_unaligned
//
// Directed bench for lsu_unaligned (DATA_W=32). A bus responder plays each
// access cycle by cycle and records what the unit put on the bus; scenario
// tasks compare the record with hand-computed values. Expectations follow the
// LSU_SPLIT_ACCESS_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_lsu_unaligned;

    logic        clk = 1'b0;
    logic        res;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_adr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        data_req;
    logic        data_gnt;
    logic [31:0] data_adr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_r_valid;

    int vectors = 0;
    int miscompares = 0;

    // what the responder saw during one access
    int          obs_nbeats;
    int          obs_lat;
    int          obs_reqcyc;
    logic        obs_hold_ok;
    logic        obs_ready_ok;
    logic [31:0] obs_adr [2];
    logic [3:0]  obs_be  [2];
    logic [31:0] obs_wd  [2];
    logic        obs_we  [2];
    logic [31:0] obs_rdata;
    logic        obs_err;

    always #5 clk = ~clk;

    lsu_unaligned #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .res(res),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_adr(req_adr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .data_req(data_req), .data_gnt(data_gnt), .data_adr(data_adr),
        .data_we(data_we), .data_be(data_be), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_r_valid(data_r_valid)
    );

    // Issue one request and act as the bus until resp_valid (bounded).
    // obs_lat counts cycles after the accepting edge; -1 means no response.
    task automatic run_access(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] adr, input logic [31:0] wd,
                              input logic [31:0] rd0, input logic [31:0] rd1,
                              input int gdly);
        logic pend;
        logic in_req;
        int   wcnt;
        int   idx;
        obs_nbeats = 0; obs_lat = -1; obs_reqcyc = 0; obs_hold_ok = 1'b1;
        obs_rdata = 'x; obs_err = 1'bx;
        pend = 1'b0; in_req = 1'b0; wcnt = 0; idx = 0;
        obs_ready_ok = (req_ready === 1'b1);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_adr = adr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_adr = '0; req_wdata = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            data_r_valid = pend;
            data_rdata   = pend ? ((obs_nbeats == 1) ? rd0 : rd1) : 32'h0;
            pend = 1'b0;
            data_gnt = 1'b0;
            if (data_req === 1'b1) begin
                obs_reqcyc++;
                idx = (obs_nbeats > 1) ? 1 : obs_nbeats;
                if (!in_req) begin
                    in_req = 1'b1;
                    obs_adr[idx] = data_adr; obs_be[idx] = data_be;
                    obs_wd[idx] = data_wdata; obs_we[idx] = data_we;
                end else if (data_adr !== obs_adr[idx] || data_be !== obs_be[idx] ||
                             data_wdata !== obs_wd[idx] || data_we !== obs_we[idx]) begin
                    obs_hold_ok = 1'b0;
                end
                if (wcnt < gdly) begin
                    wcnt++;
                end else begin
                    data_gnt = 1'b1; pend = 1'b1; in_req = 1'b0; wcnt = 0; obs_nbeats++;
                end
            end
            if (resp_valid === 1'b1) begin
                obs_lat = cyc; obs_rdata = resp_rdata; obs_err = resp_err;
            end
            @(posedge clk); #1;
            if (obs_lat >= 0) break;
        end
        data_gnt = 1'b0; data_r_valid = 1'b0; data_rdata = '0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        vectors++;
        if ({data_req, resp_valid, resp_err, resp_rdata, data_we, data_be, data_adr, data_wdata} !== '0) begin
            miscompares++;
            $display("FAIL rst_outputs: got req=%b rv=%b err=%b rd=%h we=%b be=%b adr=%h wd=%h want all 0",
                     data_req, resp_valid, resp_err, resp_rdata, data_we, data_be, data_adr, data_wdata);
        end
        #2 res = 1'b1;
        @(posedge clk); #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_load_word;
        run_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0);
        vectors++; if (obs_ready_ok !== 1'b1) begin miscompares++; $display("FAIL lw_ready: got %b want 1", obs_ready_ok); end
        vectors++; if (obs_lat != 3) begin miscompares++; $display("FAIL lw_lat: got %0d want 3", obs_lat); end
        vectors++; if (obs_nbeats != 1) begin miscompares++; $display("FAIL lw_beats: got %0d want 1", obs_nbeats); end
        vectors++; if (obs_adr[0] !== 32'h100) begin miscompares++; $display("FAIL lw_adr: got %h want 00000100", obs_adr[0]); end
        vectors++; if (obs_be[0] !== 4'b1111) begin miscompares++; $display("FAIL lw_be: got %b want 1111", obs_be[0]); end
        vectors++; if (obs_we[0] !== 1'b0) begin miscompares++; $display("FAIL lw_we: got %b want 0", obs_we[0]); end
        vectors++; if (obs_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_rdata: got %h want deadbeef", obs_rdata); end
        vectors++; if (obs_err !== 1'b0) begin miscompares++; $display("FAIL lw_err: got %b want 0", obs_err); end
    endtask

    task automatic test_load_half_split;
        run_access(1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 32'hF0000000, 32'h00000081, 0);
`ifdef LSU_SPLIT_ACCESS_EN
        vectors++; if (obs_lat != 5) begin miscompares++; $display("FAIL lhs_lat: got %0d want 5", obs_lat); end
        vectors++; if (obs_nbeats != 2) begin miscompares++; $display("FAIL lhs_beats: got %0d want 2", obs_nbeats); end
        vectors++; if (obs_adr[0] !== 32'h100 || obs_be[0] !== 4'b1000) begin miscompares++; $display("FAIL lhs_beat0: got %h/%b want 00000100/1000", obs_adr[0], obs_be[0]); end
        vectors++; if (obs_adr[1] !== 32'h104 || obs_be[1] !== 4'b0001) begin miscompares++; $display("FAIL lhs_beat1: got %h/%b want 00000104/0001", obs_adr[1], obs_be[1]); end
        vectors++; if (obs_rdata !== 32'hFFFF81F0) begin miscompares++; $display("FAIL lhs_rdata: got %h want ffff81f0", obs_rdata); end
        vectors++; if (obs_err !== 1'b0) begin miscompares++; $display("FAIL lhs_err: got %b want 0", obs_err); end
`else
        vectors++; if (obs_lat != 1) begin miscompares++; $display("FAIL lhs_mis_lat: got %0d want 1", obs_lat); end
        vectors++; if (obs_err !== 1'b1) begin miscompares++; $display("FAIL lhs_mis_err: got %b want 1", obs_err); end
        vectors++; if (obs_reqcyc != 0) begin miscompares++; $display("FAIL lhs_mis_bus: got %0d req cycles want 0", obs_reqcyc); end
        vectors++; if (obs_rdata !== 32'h0) begin miscompares++; $display("FAIL lhs_mis_rdata: got %h want 00000000", obs_rdata); end
`endif
    endtask

    task automatic test_store_split;
        run_access(1'b1, 2'd2, 1'b0, 32'h006, 32'h11223344, 32'h0, 32'h0, 0);
`ifdef LSU_SPLIT_ACCESS_EN
        vectors++; if (obs_lat != 5) begin miscompares++; $display("FAIL sws_lat: got %0d want 5", obs_lat); end
        vectors++; if (obs_adr[0] !== 32'h004 || obs_be[0] !== 4'b1100 || obs_wd[0] !== 32'h33440000 || obs_we[0] !== 1'b1) begin
            miscompares++; $display("FAIL sws_beat0: got %h/%b/%h/%b want 00000004/1100/33440000/1", obs_adr[0], obs_be[0], obs_wd[0], obs_we[0]); end
        vectors++; if (obs_adr[1] !== 32'h008 || obs_be[1] !== 4'b0011 || obs_wd[1] !== 32'h00001122 || obs_we[1] !== 1'b1) begin
            miscompares++; $display("FAIL sws_beat1: got %h/%b/%h/%b want 00000008/0011/00001122/1", obs_adr[1], obs_be[1], obs_wd[1], obs_we[1]); end
        vectors++; if (obs_rdata !== 32'h0 || obs_err !== 1'b0) begin miscompares++; $display("FAIL sws_resp: got %h/%b want 00000000/0", obs_rdata, obs_err); end
`else
        vectors++; if (obs_lat != 1 || obs_err !== 1'b1) begin miscompares++; $display("FAIL sws_mis: got lat %0d err %b want 1/1", obs_lat, obs_err); end
        vectors++; if (obs_reqcyc != 0) begin miscompares++; $display("FAIL sws_mis_bus: got %0d req cycles want 0", obs_reqcyc); end
`endif
    endtask

    task automatic test_gnt_delay;
        run_access(1'b0, 2'd0, 1'b0, 32'h201, 32'h0, 32'h0000AB00, 32'h0, 3);
        vectors++; if (obs_reqcyc != 4) begin miscompares++; $display("FAIL gd_reqcyc: got %0d want 4", obs_reqcyc); end
        vectors++; if (obs_hold_ok !== 1'b1) begin miscompares++; $display("FAIL gd_hold: got %b want 1", obs_hold_ok); end
        vectors++; if (obs_adr[0] !== 32'h200 || obs_be[0] !== 4'b0010) begin miscompares++; $display("FAIL gd_bus: got %h/%b want 00000200/0010", obs_adr[0], obs_be[0]); end
        vectors++; if (obs_lat != 6) begin miscompares++; $display("FAIL gd_lat: got %0d want 6", obs_lat); end
        vectors++; if (obs_rdata !== 32'h000000AB) begin miscompares++; $display("FAIL gd_rdata: got %h want 000000ab", obs_rdata); end
    endtask

    task automatic test_wrap;
        run_access(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h55667788, 32'h11223344, 0);
`ifdef LSU_SPLIT_ACCESS_EN
        vectors++; if (obs_adr[0] !== 32'hFFFFFFFC || obs_be[0] !== 4'b1100) begin miscompares++; $display("FAIL wrap_beat0: got %h/%b want fffffffc/1100", obs_adr[0], obs_be[0]); end
        vectors++; if (obs_adr[1] !== 32'h00000000 || obs_be[1] !== 4'b0011) begin miscompares++; $display("FAIL wrap_beat1: got %h/%b want 00000000/0011", obs_adr[1], obs_be[1]); end
        vectors++; if (obs_rdata !== 32'h33445566) begin miscompares++; $display("FAIL wrap_rdata: got %h want 33445566", obs_rdata); end
`else
        vectors++; if (obs_lat != 1 || obs_err !== 1'b1 || obs_reqcyc != 0) begin
            miscompares++; $display("FAIL wrap_mis: got lat %0d err %b reqcyc %0d want 1/1/0", obs_lat, obs_err, obs_reqcyc); end
`endif
    endtask

    // phase 0: reset while data_req is up and ungranted; phase 1: reset in WAIT0
    task automatic test_reset_mid(input int phase);
        logic [31:0] adr;
        logic        rv_seen;
        logic        req_seen;
`ifdef LSU_SPLIT_ACCESS_EN
        adr = 32'hFFFFFFFE;
`else
        adr = 32'h00000100;
`endif
        rv_seen = 1'b0; req_seen = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_adr = adr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        vectors++; if (data_req !== 1'b1) begin miscompares++; $display("FAIL rm%0d_req_up: got %b want 1", phase, data_req); end
        if (phase == 1) begin
            data_gnt = 1'b1;
            @(posedge clk); #1;
            data_gnt = 1'b0;
        end
        #2 res = 1'b0;
        #1;
        vectors++; if (data_req !== 1'b0) begin miscompares++; $display("FAIL rm%0d_req_drop: got %b want 0", phase, data_req); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rm%0d_ready_low: got %b want 0", phase, req_ready); end
        data_r_valid = 1'b1; data_rdata = 32'h12345678;
        @(posedge clk); #2;
        res = 1'b1;
        @(posedge clk); #1;
        data_r_valid = 1'b0;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rm%0d_ready_back: got %b want 1", phase, req_ready); end
        for (int i = 0; i < 4; i++) begin
            if (resp_valid === 1'b1) rv_seen = 1'b1;
            if (data_req === 1'b1) req_seen = 1'b1;
            data_r_valid = (i == 1);
            @(posedge clk); #1;
        end
        data_r_valid = 1'b0;
        vectors++; if (rv_seen !== 1'b0 || req_seen !== 1'b0) begin miscompares++; $display("FAIL rm%0d_dropped: got rv %b req %b want 0/0", phase, rv_seen, req_seen); end
    endtask

    task automatic test_extend;
        run_access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h80011234, 32'h0, 0);
        vectors++; if (obs_rdata !== 32'hFFFF8001 || obs_be[0] !== 4'b1100) begin miscompares++; $display("FAIL lh_s: got %h/%b want ffff8001/1100", obs_rdata, obs_be[0]); end
        run_access(1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 32'h1234FFEE, 32'h0, 0);
        vectors++; if (obs_rdata !== 32'h0000FFEE) begin miscompares++; $display("FAIL lh_u: got %h want 0000ffee", obs_rdata); end
        run_access(1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 32'h80000000, 32'h0, 0);
        vectors++; if (obs_rdata !== 32'hFFFFFF80 || obs_be[0] !== 4'b1000) begin miscompares++; $display("FAIL lb_s: got %h/%b want ffffff80/1000", obs_rdata, obs_be[0]); end
        run_access(1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 32'h80000000, 32'h0, 0);
        vectors++; if (obs_rdata !== 32'h00000080) begin miscompares++; $display("FAIL lb_u: got %h want 00000080", obs_rdata); end
        run_access(1'b1, 2'd0, 1'b0, 32'h003, 32'h000000A5, 32'h0, 32'h0, 0);
        vectors++; if (obs_be[0] !== 4'b1000 || obs_wd[0] !== 32'hA5000000 || obs_we[0] !== 1'b1) begin
            miscompares++; $display("FAIL sb: got %b/%h/%b want 1000/a5000000/1", obs_be[0], obs_wd[0], obs_we[0]); end
        vectors++; if (obs_rdata !== 32'h0 || obs_lat != 3) begin miscompares++; $display("FAIL sb_resp: got %h lat %0d want 00000000 lat 3", obs_rdata, obs_lat); end
    endtask

    task automatic test_half_inword;
        run_access(1'b0, 2'd1, 1'b1, 32'h101, 32'h0, 32'h00F00D00, 32'h0, 0);
`ifdef LSU_SPLIT_ACCESS_EN
        vectors++; if (obs_lat != 3 || obs_nbeats != 1) begin miscompares++; $display("FAIL lh101_lat: got %0d/%0d want 3/1", obs_lat, obs_nbeats); end
        vectors++; if (obs_be[0] !== 4'b0110) begin miscompares++; $display("FAIL lh101_be: got %b want 0110", obs_be[0]); end
        vectors++; if (obs_rdata !== 32'hFFFFF00D) begin miscompares++; $display("FAIL lh101_rdata: got %h want fffff00d", obs_rdata); end
`else
        vectors++; if (obs_lat != 1 || obs_err !== 1'b1 || obs_reqcyc != 0) begin
            miscompares++; $display("FAIL lh101_mis: got lat %0d err %b reqcyc %0d want 1/1/0", obs_lat, obs_err, obs_reqcyc); end
`endif
    endtask

    task automatic test_illegal_size;
        run_access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'hCAFEF00D, 32'h0, 0);
        vectors++; if (obs_lat != 1) begin miscompares++; $display("FAIL ld64_lat: got %0d want 1", obs_lat); end
        vectors++; if (obs_err !== 1'b1) begin miscompares++; $display("FAIL ld64_err: got %b want 1", obs_err); end
        vectors++; if (obs_reqcyc != 0) begin miscompares++; $display("FAIL ld64_bus: got %0d req cycles want 0", obs_reqcyc); end
        vectors++; if (obs_rdata !== 32'h0) begin miscompares++; $display("FAIL ld64_rdata: got %h want 00000000", obs_rdata); end
    endtask

    initial begin
        res = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_adr = '0; req_wdata = '0;
        data_gnt = 1'b0; data_rdata = '0; data_r_valid = 1'b0;
        test_reset;
        test_load_word;
        test_load_half_split;
        test_store_split;
        test_gnt_delay;
        test_wrap;
        test_reset_mid(0);
        test_reset_mid(1);
        test_extend;
        test_half_inword;
        test_illegal_size;
        test_load_word;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
